mem_ctrl_dual: RTL and testbench
================================

# mem_ctrl_dual

Dual-channel memory controller between the instruction-fetch unit, the load/store unit and a two-port synchronous RAM. Port A serves instruction fetch. Port B serves loads and stores. Each channel runs its own FSM with a parametrised RAM read latency. Port B adds byte/half/word access with byte-lane write masks and sign/zero extension on loads, and the fetch channel supports flush.

## Interface
- ADDR_WIDTH, 32, byte address width; only [17:0] reaches RAM.
- DATA_WIDTH, 32, RAM word width; 32 is the only supported value.
- RAM_LATENCY, 1, edges from the address register update to data valid on data_a/data_b; legal range 1..7.
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- if_valid  in  1  fetch request
- if_addr  in  ADDR_WIDTH  fetch byte address; word-aligned, bits [1:0] ignored
- if_flush  in  1  abort the in-flight fetch
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  DATA_WIDTH  registered fetch word
- ls_valid  in  1  load/store request
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ls_signed  in  1  load sign-extend when 1, zero-extend when 0
- ls_addr  in  ADDR_WIDTH  byte address
- ls_src  in  DATA_WIDTH  store data, right-aligned
- ls_done  out  1  one-cycle pulse; ls_data valid for loads
- ls_data  out  DATA_WIDTH  registered, extended load result
- addr_a  out  ADDR_WIDTH  port A word address ({addr[31:2],2'b00})
- data_a  in  DATA_WIDTH  port A read data
- addr_b  out  ADDR_WIDTH  port B word address
- wr_b  out  1  port B write strobe
- wmask_b  out  DATA_WIDTH/8  byte-lane enables; 0 whenever wr_b=0
- src_b  out  DATA_WIDTH  lane-shifted store data
- data_b  in  DATA_WIDTH  port B read data

## Operation
- Reset: every output is 0. Both FSMs go to IDLE and both latency counters clear. An access in flight at reset is abandoned; no done pulse follows.
- IF FSM states: IDLE, WAIT.
  - IDLE and if_valid and not if_flush at an edge: latch the aligned address into addr_a, load the counter with RAM_LATENCY-1, go to WAIT.
  - WAIT, counter 0: if_data <= data_a, if_done <= 1, go to IDLE.
  - WAIT, counter not 0: decrement the counter.
- if_flush at any edge: FSM goes to IDLE and if_done <= 0. It has priority over a concurrent if_valid and over a completing WAIT, so no data update and no pulse.
- LS FSM states: IDLE, RD_WAIT, WR.
  - Load accept: addr_b <= aligned address; latch size, signed flag and addr[1:0]; go to RD_WAIT. Counter behaviour matches the IF FSM.
  - Load completion: extract the lane from data_b and extend into ls_data, pulse ls_done.
  - Store accept: addr_b <= aligned address, wr_b <= 1, wmask_b and src_b set, go to WR.
  - WR, next edge: wr_b <= 0, wmask_b <= 0, ls_done <= 1, go to IDLE. Store latency does not depend on RAM_LATENCY.
- Lane rules:
  - byte: lane = addr[1:0], mask 0001<<lane, src_b = ls_src[7:0]<<(8*lane).
  - half: lane = 2*addr[1], mask 0011<<lane; addr[0] ignored.
  - word: mask 1111; addr[1:0] ignored.
- Channels are independent and may complete at the same edge. if_flush does not touch the LS channel.
- Requests arriving while a channel is busy are ignored. The requester holds valid until it sees done.
- Done cycle: the FSM is already IDLE, so valid still high at that edge starts a new access. Throughput is one access per RAM_LATENCY+1 cycles per channel.
- addr_a and addr_b hold their last value when idle. ls_data and if_data hold until the next completion.

## Timing
- Fetch/load accepted at edge T:
  - address visible after T;
  - data sampled at edge T+RAM_LATENCY;
  - done high for the cycle after that edge.
- Store accepted at edge T: wr_b and wmask_b high for exactly the cycle after T. ls_done is high for the cycle after T+1.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan
- RAM_LATENCY=1, fetch 0x104 with mem[0x104]=0xDEADBEEF:
  - addr_a=0x104 after edge 0;
  - if_done for 1 cycle after edge 1;
  - if_data=0xDEADBEEF.
- RAM_LATENCY=3, back-to-back fetches 0x0 then 0x4 with valid held: done pulses after edges 3 and 7, each with the correct word.
- Store byte 0xA5 at 0x203, then load signed byte 0x203:
  - wmask_b=1000, src_b=0xA5000000, wr_b for one cycle;
  - load returns 0xFFFFFFA5; unsigned load returns 0x000000A5.
- Store half 0x8001 at 0x12, then load signed half: mask 1100; ls_data=0xFFFF8001.
- Fetch in WAIT with RAM_LATENCY=3, if_flush at edge 2 while a load runs on port B: no if_done, if_data unchanged, load still completes normally.
- rst asserted during a load's RD_WAIT: all outputs are 0 next cycle, no ls_done, and a new request after reset completes normally.

Source files
------------

// File: rtl/mem_ctrl_dual.sv
// -----------------------------------------------------------------------------
// mem_ctrl_dual
//
// Dual-channel controller sitting between the instruction-fetch unit, the
// load/store unit and a two-port synchronous RAM.
//   Port A : instruction fetch (word reads only, abortable with if_flush).
//   Port B : loads and stores with byte/half/word sizes, byte-lane write masks
//            and sign/zero extension of load results.
// Each channel has its own small FSM and a down-counter that covers the RAM
// read latency (RAM_LATENCY edges from the address register update until the
// read data is valid on data_a/data_b). All outputs are registered.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_addr         fetch request (byte address, low two bits ignored)
//   if_flush                 abort the in-flight fetch, beats a concurrent request
//   if_done/if_data          one-cycle completion pulse and registered fetch word
//   ls_valid/ls_we           load/store request, ls_we=1 for store
//   ls_size/ls_signed        00 byte, 01 half, 1x word; sign-extend loads when set
//   ls_addr/ls_src           byte address and right-aligned store data
//   ls_done/ls_data          one-cycle completion pulse and extended load result
//   addr_a/data_a            RAM port A word address and read data
//   addr_b/data_b            RAM port B word address and read data
//   wr_b/wmask_b/src_b       RAM port B write strobe, byte enables, lane-shifted data
// -----------------------------------------------------------------------------
module mem_ctrl_dual #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,  // only 32 is supported
  parameter int RAM_LATENCY = 1    // legal range 1..7
) (
  input  logic                    clk,
  input  logic                    rst,
  // fetch channel
  input  logic                    if_valid,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic                    if_done,
  output logic [DATA_WIDTH-1:0]   if_data,
  // load/store channel
  input  logic                    ls_valid,
  input  logic                    ls_we,
  input  logic [1:0]              ls_size,
  input  logic                    ls_signed,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_src,
  output logic                    ls_done,
  output logic [DATA_WIDTH-1:0]   ls_data,
  // RAM port A
  output logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   data_a,
  // RAM port B
  output logic [ADDR_WIDTH-1:0]   addr_b,
  output logic                    wr_b,
  output logic [DATA_WIDTH/8-1:0] wmask_b,
  output logic [DATA_WIDTH-1:0]   src_b,
  input  logic [DATA_WIDTH-1:0]   data_b
);

  localparam int         NB       = DATA_WIDTH / 8;
  localparam logic [2:0] CNT_LOAD = 3'(RAM_LATENCY - 1);
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  typedef enum logic {
    IF_IDLE,
    IF_WAIT
  } if_state_e;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_RD_WAIT,
    LS_WR
  } ls_state_e;

  // Fetch addresses are word-aligned by construction; the low bits are dropped.
  logic unused_if_lo;
  assign unused_if_lo = ^if_addr[1:0];

  // ---------------------------------------------------------------------------
  // Fetch channel
  // ---------------------------------------------------------------------------
  if_state_e             if_state_q, if_state_d;
  logic [2:0]            if_cnt_q,   if_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_a_q,   addr_a_d;
  logic [DATA_WIDTH-1:0] if_data_q,  if_data_d;
  logic                  if_done_q,  if_done_d;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    if_state_d = if_state_q;
    if_cnt_d   = if_cnt_q;
    addr_a_d   = addr_a_q;
    if_data_d  = if_data_q;
    if_done_d  = 1'b0;

    if (if_flush) begin
      // Flush wins over both a new request and a completing wait.
      if_state_d = IF_IDLE;
    end else begin
      unique case (if_state_q)
        IF_IDLE: begin
          if (if_valid) begin
            addr_a_d   = {if_addr[ADDR_WIDTH-1:2], 2'b00};
            if_cnt_d   = CNT_LOAD;
            if_state_d = IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (if_cnt_q == 3'd0) begin
            if_data_d  = data_a;
            if_done_d  = 1'b1;
            if_state_d = IF_IDLE;
          end else begin
            if_cnt_d = if_cnt_q - 3'd1;
          end
        end
        default: if_state_d = IF_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  // NOTE: the data registers are reset along with the control state because
  // every output must read 0 out of reset; there is no storage array here that
  // would make a full reset expensive.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_state_q <= IF_IDLE;
      if_cnt_q   <= '0;
      addr_a_q   <= '0;
      if_data_q  <= '0;
      if_done_q  <= 1'b0;
    end else begin
      if_state_q <= if_state_d;
      if_cnt_q   <= if_cnt_d;
      addr_a_q   <= addr_a_d;
      if_data_q  <= if_data_d;
      if_done_q  <= if_done_d;
    end
  end

  assign addr_a  = addr_a_q;
  assign if_data = if_data_q;
  assign if_done = if_done_q;

  // ---------------------------------------------------------------------------
  // Load/store channel
  // ---------------------------------------------------------------------------
  ls_state_e             ls_state_q, ls_state_d;
  logic [2:0]            ls_cnt_q,   ls_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_b_q,   addr_b_d;
  logic                  wr_b_q,     wr_b_d;
  logic [NB-1:0]         wmask_b_q,  wmask_b_d;
  logic [DATA_WIDTH-1:0] src_b_q,    src_b_d;
  logic [DATA_WIDTH-1:0] ls_data_q,  ls_data_d;
  logic                  ls_done_q,  ls_done_d;
  // Load attributes captured at accept; the request inputs may change while
  // the read is outstanding.
  logic [1:0]            size_q,     size_d;
  logic                  signed_q,   signed_d;
  logic [1:0]            lo_q,       lo_d;

  // Store lane placement from the live request: byte lane = addr[1:0],
  // half lane = 2*addr[1], word covers all four lanes.
  logic [NB-1:0]         st_mask;
  logic [DATA_WIDTH-1:0] st_src;

  always_comb begin
    st_mask = '1;
    st_src  = ls_src;
    case (ls_size)
      SZ_BYTE: begin
        st_mask = NB'(1) << ls_addr[1:0];
        st_src  = DATA_WIDTH'(ls_src[7:0]) << {ls_addr[1:0], 3'b000};
      end
      SZ_HALF: begin
        st_mask = NB'(3) << {ls_addr[1], 1'b0};
        st_src  = DATA_WIDTH'(ls_src[15:0]) << {ls_addr[1], 4'b0000};
      end
      default: ;
    endcase
  end

  // Load lane extraction from the RAM word using the captured attributes.
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    ld_byte = 8'(data_b >> {lo_q, 3'b000});
    ld_half = 16'(data_b >> {lo_q[1], 4'b0000});
    ld_ext  = data_b;
    case (size_q)
      SZ_BYTE: ld_ext = {{(DATA_WIDTH-8){signed_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = {{(DATA_WIDTH-16){signed_q & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_comb begin
    ls_state_d = ls_state_q;
    ls_cnt_d   = ls_cnt_q;
    addr_b_d   = addr_b_q;
    wr_b_d     = 1'b0;
    wmask_b_d  = '0;
    src_b_d    = src_b_q;
    ls_data_d  = ls_data_q;
    ls_done_d  = 1'b0;
    size_d     = size_q;
    signed_d   = signed_q;
    lo_d       = lo_q;

    unique case (ls_state_q)
      LS_IDLE: begin
        if (ls_valid) begin
          addr_b_d = {ls_addr[ADDR_WIDTH-1:2], 2'b00};
          if (ls_we) begin
            wr_b_d     = 1'b1;
            wmask_b_d  = st_mask;
            src_b_d    = st_src;
            ls_state_d = LS_WR;
          end else begin
            size_d     = ls_size;
            signed_d   = ls_signed;
            lo_d       = ls_addr[1:0];
            ls_cnt_d   = CNT_LOAD;
            ls_state_d = LS_RD_WAIT;
          end
        end
      end
      LS_RD_WAIT: begin
        if (ls_cnt_q == 3'd0) begin
          ls_data_d  = ld_ext;
          ls_done_d  = 1'b1;
          ls_state_d = LS_IDLE;
        end else begin
          ls_cnt_d = ls_cnt_q - 3'd1;
        end
      end
      LS_WR: begin
        // The write strobe was up for exactly one cycle; it drops by default.
        ls_done_d  = 1'b1;
        ls_state_d = LS_IDLE;
      end
      default: ls_state_d = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ls_state_q <= LS_IDLE;
      ls_cnt_q   <= '0;
      addr_b_q   <= '0;
      wr_b_q     <= 1'b0;
      wmask_b_q  <= '0;
      src_b_q    <= '0;
      ls_data_q  <= '0;
      ls_done_q  <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      lo_q       <= '0;
    end else begin
      ls_state_q <= ls_state_d;
      ls_cnt_q   <= ls_cnt_d;
      addr_b_q   <= addr_b_d;
      wr_b_q     <= wr_b_d;
      wmask_b_q  <= wmask_b_d;
      src_b_q    <= src_b_d;
      ls_data_q  <= ls_data_d;
      ls_done_q  <= ls_done_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      lo_q       <= lo_d;
    end
  end

  assign addr_b  = addr_b_q;
  assign wr_b    = wr_b_q;
  assign wmask_b = wmask_b_q;
  assign src_b   = src_b_q;
  assign ls_data = ls_data_q;
  assign ls_done = ls_done_q;

endmodule

// File: tb/tb_mem_ctrl_dual.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl_dual
//
// Two instances of mem_ctrl_dual share clk/rst: channel 0 with RAM_LATENCY=1,
// channel 1 with RAM_LATENCY=3. Each has its own two-port RAM model (written
// only by the DUT's port B strobes) and a reference memory image updated from
// the byte/half/word store rules. Expected fetch and load values come from the
// reference image. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_ctrl_dual;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       if_valid, if_flush, ls_valid, ls_we, ls_signed;
  logic [1:0][1:0]  ls_size;
  logic [1:0][31:0] if_addr, ls_addr, ls_src;
  wire  [1:0]       if_done, ls_done, wr_b;
  wire  [1:0][31:0] if_data, ls_data, addr_a, addr_b, src_b, data_a, data_b;
  wire  [1:0][3:0]  wmask_b;

  logic [31:0] mem     [2][MEM_WORDS];
  logic [31:0] ref_mem [2][MEM_WORDS];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] pipe_a [8];
    logic [31:0] pipe_b [8];
    wire  [31:0] rd_a = mem[g][addr_a[g][9:2]];
    wire  [31:0] rd_b = mem[g][addr_b[g][9:2]];

    always @(posedge clk) begin
      pipe_a[0] <= rd_a;
      pipe_b[0] <= rd_b;
      for (int i = 1; i < 8; i++) begin
        pipe_a[i] <= pipe_a[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
      if (wr_b[g])
        for (int j = 0; j < 4; j++)
          if (wmask_b[g][j]) mem[g][addr_b[g][9:2]][8*j +: 8] <= src_b[g][8*j +: 8];
    end

    if (LAT == 1) begin : g_l1
      assign data_a[g] = rd_a;
      assign data_b[g] = rd_b;
    end else begin : g_ln
      assign data_a[g] = pipe_a[LAT-2];
      assign data_b[g] = pipe_b[LAT-2];
    end

    mem_ctrl_dual #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_valid (if_valid[g]),
      .if_addr  (if_addr[g]),
      .if_flush (if_flush[g]),
      .if_done  (if_done[g]),
      .if_data  (if_data[g]),
      .ls_valid (ls_valid[g]),
      .ls_we    (ls_we[g]),
      .ls_size  (ls_size[g]),
      .ls_signed(ls_signed[g]),
      .ls_addr  (ls_addr[g]),
      .ls_src   (ls_src[g]),
      .ls_done  (ls_done[g]),
      .ls_data  (ls_data[g]),
      .addr_a   (addr_a[g]),
      .data_a   (data_a[g]),
      .addr_b   (addr_b[g]),
      .wr_b     (wr_b[g]),
      .wmask_b  (wmask_b[g]),
      .src_b    (src_b[g]),
      .data_b   (data_b[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string name, input int k);
    return $sformatf("%s[ch%0d]", name, k);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int lane_of(input logic [31:0] a, input logic [1:0] size);
    if (size == 2'b00) return int'(a[1:0]);
    if (size == 2'b01) return 2 * int'(a[1]);
    return 0;
  endfunction

  function automatic int bytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [31:0] a, input logic [1:0] size);
    int m;
    m = ((1 << bytes_of(size)) - 1) << lane_of(a, size);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_src(input logic [31:0] a, input logic [1:0] size,
                                          input logic [31:0] d);
    logic [31:0] keep;
    keep = (bytes_of(size) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes_of(size))) - 1);
    return (d & keep) << (8 * lane_of(a, size));
  endfunction

  function automatic void ref_store(input int k, input logic [31:0] a, input logic [1:0] size,
                                    input logic [31:0] d);
    logic [31:0] w;
    int base;
    w    = ref_mem[k][a[9:2]];
    base = lane_of(a, size);
    for (int i = 0; i < bytes_of(size); i++) w[8*(base+i) +: 8] = d[8*i +: 8];
    ref_mem[k][a[9:2]] = w;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [31:0] a,
                                           input logic [1:0] size, input logic sgn);
    logic [31:0] w, v;
    w = ref_mem[k][a[9:2]];
    v = w;
    if (size == 2'b00) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (sgn && v > 32'd127) v = v - 32'd256;
    end else if (size == 2'b01) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (sgn && v > 32'd32767) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic poke(input int k, input logic [31:0] a, input logic [31:0] v);
    mem[k][a[9:2]]     = v;
    ref_mem[k][a[9:2]] = v;
  endtask

  task automatic check_zero(input int k);
    check(tg("rst_if_done", k), 32'(if_done[k]), 32'd0);
    check(tg("rst_if_data", k), if_data[k], 32'd0);
    check(tg("rst_ls_done", k), 32'(ls_done[k]), 32'd0);
    check(tg("rst_ls_data", k), ls_data[k], 32'd0);
    check(tg("rst_addr_a", k), addr_a[k], 32'd0);
    check(tg("rst_addr_b", k), addr_b[k], 32'd0);
    check(tg("rst_wr_b", k), 32'(wr_b[k]), 32'd0);
    check(tg("rst_wmask_b", k), 32'(wmask_b[k]), 32'd0);
    check(tg("rst_src_b", k), src_b[k], 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Transactions (start at a falling edge, end at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_fetch(input int k, input logic [31:0] a);
    int n;
    logic [31:0] exp_w;
    exp_w = ref_mem[k][a[9:2]];
    @(negedge clk);
    if_valid[k] = 1'b1;
    if_addr[k]  = a;
    @(negedge clk);
    n = 1;
    check(tg("if_addr_a", k), addr_a[k], {a[31:2], 2'b00});
    while (!if_done[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if_valid[k] = 1'b0;
    check(tg("if_latency", k), 32'(n), 32'(lat_of(k) + 1));
    check(tg("if_data", k), if_data[k], exp_w);
    @(negedge clk);
    check(tg("if_done_pulse", k), 32'(if_done[k]), 32'd0);
  endtask

  task automatic do_load(input int k, input logic [31:0] a, input logic [1:0] size,
                         input logic sgn, output logic [31:0] obs);
    int n;
    logic [31:0] exp_v;
    exp_v = ref_load(k, a, size, sgn);
    @(negedge clk);
    ls_valid[k]  = 1'b1;
    ls_we[k]     = 1'b0;
    ls_addr[k]   = a;
    ls_size[k]   = size;
    ls_signed[k] = sgn;
    ls_src[k]    = $urandom;
    @(negedge clk);
    n = 1;
    check(tg("ld_addr_b", k), addr_b[k], {a[31:2], 2'b00});
    check(tg("ld_no_wr", k), 32'({wr_b[k], wmask_b[k]}), 32'd0);
    while (!ls_done[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    ls_valid[k] = 1'b0;
    check(tg("ld_latency", k), 32'(n), 32'(lat_of(k) + 1));
    check(tg("ld_data", k), ls_data[k], exp_v);
    obs = ls_data[k];
    @(negedge clk);
    check(tg("ld_done_pulse", k), 32'(ls_done[k]), 32'd0);
  endtask

  task automatic do_store(input int k, input logic [31:0] a, input logic [1:0] size,
                          input logic [31:0] d, output logic [3:0] m_obs,
                          output logic [31:0] s_obs);
    @(negedge clk);
    ls_valid[k]  = 1'b1;
    ls_we[k]     = 1'b1;
    ls_addr[k]   = a;
    ls_size[k]   = size;
    ls_signed[k] = 1'($urandom);
    ls_src[k]    = d;
    @(negedge clk);
    ls_valid[k] = 1'b0;
    ls_we[k]    = 1'b0;
    check(tg("st_wr_b", k), 32'(wr_b[k]), 32'd1);
    check(tg("st_wmask", k), 32'(wmask_b[k]), 32'(ref_mask(a, size)));
    check(tg("st_src_b", k), src_b[k], ref_src(a, size, d));
    check(tg("st_addr_b", k), addr_b[k], {a[31:2], 2'b00});
    check(tg("st_early_done", k), 32'(ls_done[k]), 32'd0);
    m_obs = wmask_b[k];
    s_obs = src_b[k];
    @(negedge clk);
    check(tg("st_wr_b_drop", k), 32'({wr_b[k], wmask_b[k]}), 32'd0);
    check(tg("st_done", k), 32'(ls_done[k]), 32'd1);
    @(negedge clk);
    check(tg("st_done_pulse", k), 32'(ls_done[k]), 32'd0);
    ref_store(k, a, size, d);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and randomised sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] obs, prev, w1, w2, a, a2, d;
    logic [3:0]  m_obs;
    logic [1:0]  sz;
    logic        sg;
    int          d1, d2, if_seen, ls_at, k, op, cnt;

    rst = 1'b1;
    if_valid = '0; if_flush = '0; ls_valid = '0; ls_we = '0; ls_signed = '0;
    ls_size = '0; if_addr = '0; ls_addr = '0; ls_src = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < MEM_WORDS; i++) poke(c, 32'(i * 4), $urandom);

    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst = 1'b0;

    // Fetch 0x104 with latency 1.
    poke(0, 32'h104, 32'hDEAD_BEEF);
    do_fetch(0, 32'h104);
    check("tp_fetch_word[ch0]", if_data[0], 32'hDEAD_BEEF);

    // Back-to-back fetches 0x0 then 0x4 with latency 3 and valid held.
    poke(1, 32'h0, $urandom);
    poke(1, 32'h4, $urandom);
    @(negedge clk);
    if_valid[1] = 1'b1;
    if_addr[1]  = 32'h0;
    d1 = 0; d2 = 0; w1 = '0; w2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (if_done[1]) begin
        if (d1 == 0) begin
          d1 = c; w1 = if_data[1]; if_addr[1] = 32'h4;
        end else if (d2 == 0) begin
          d2 = c; w2 = if_data[1]; if_valid[1] = 1'b0;
        end
      end
    end
    if_valid[1] = 1'b0;
    check("b2b_first_edge[ch1]", 32'(d1), 32'd4);
    check("b2b_second_edge[ch1]", 32'(d2), 32'd8);
    check("b2b_first_word[ch1]", w1, ref_mem[1][0]);
    check("b2b_second_word[ch1]", w2, ref_mem[1][1]);

    // Byte store 0xA5 at 0x203, then signed and unsigned byte loads.
    do_store(1, 32'h203, 2'b00, 32'h1234_56A5, m_obs, obs);
    check("tp_byte_mask[ch1]", 32'(m_obs), 32'h8);
    check("tp_byte_src[ch1]", obs, 32'hA500_0000);
    do_load(1, 32'h203, 2'b00, 1'b1, obs);
    check("tp_byte_signed[ch1]", obs, 32'hFFFF_FFA5);
    do_load(1, 32'h203, 2'b00, 1'b0, obs);
    check("tp_byte_unsigned[ch1]", obs, 32'h0000_00A5);

    // Half store 0x8001 at 0x12, then signed half load.
    do_store(0, 32'h12, 2'b01, 32'hFFFF_8001, m_obs, obs);
    check("tp_half_mask[ch0]", 32'(m_obs), 32'hC);
    do_load(0, 32'h12, 2'b01, 1'b1, obs);
    check("tp_half_signed[ch0]", obs, 32'hFFFF_8001);

    // Flush at edge 2 of a latency-3 fetch while a load runs on port B.
    prev = if_data[1];
    poke(1, 32'h80, ~prev);
    w1 = ref_load(1, 32'h2C6, 2'b01, 1'b1);
    @(negedge clk);
    if_valid[1] = 1'b1; if_addr[1] = 32'h80;
    ls_valid[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h2C6;
    ls_size[1] = 2'b01; ls_signed[1] = 1'b1;
    if_seen = 0; ls_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin if_valid[1] = 1'b0; ls_valid[1] = 1'b0; end
      if (c == 2) if_flush[1] = 1'b1;
      if (c == 3) if_flush[1] = 1'b0;
      if (if_done[1]) if_seen++;
      if (ls_done[1] && ls_at == 0) ls_at = c;
    end
    check("flush_no_done[ch1]", 32'(if_seen), 32'd0);
    check("flush_data_held[ch1]", if_data[1], prev);
    check("flush_load_edge[ch1]", 32'(ls_at), 32'd4);
    check("flush_load_data[ch1]", ls_data[1], w1);

    // Flush coinciding with a request in IDLE: the request is not taken.
    prev = addr_a[0];
    @(negedge clk);
    if_valid[0] = 1'b1; if_flush[0] = 1'b1; if_addr[0] = 32'h3F0;
    @(negedge clk);
    if_valid[0] = 1'b0; if_flush[0] = 1'b0;
    if_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_done[0]) if_seen++;
    end
    check("flush_idle_no_done[ch0]", 32'(if_seen), 32'd0);
    check("flush_idle_addr_held[ch0]", addr_a[0], prev);

    // Randomised traffic on both channels.
    for (int i = 0; i < 60; i++) begin
      k  = i % 2;
      op = int'($urandom_range(0, 3));
      a  = $urandom;
      a2 = $urandom;
      d  = $urandom;
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      case (op)
        0: do_fetch(k, a);
        1: do_load(k, a, sz, sg, obs);
        2: do_store(k, a, sz, d, m_obs, obs);
        default: begin
          fork
            do_fetch(k, a);
            do_load(k, a2, sz, sg, obs);
          join
        end
      endcase
    end

    // Reset during a load's read wait.
    @(negedge clk);
    ls_valid[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h100; ls_size[1] = 2'b10;
    @(negedge clk);
    ls_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero(0);
    check_zero(1);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ls_done[1]) cnt++;
    end
    check("rst_no_ls_done[ch1]", 32'(cnt), 32'd0);
    do_load(1, 32'h100, 2'b10, 1'b0, obs);
    do_fetch(1, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
